// File: rtl/pio_valid_m10k_writer.sv
// ============================================================================
// Module   : pio_valid_m10k_writer
// Purpose  : Four-phase VALID/ACK PIO handshake writing one pixel per request
//            into an M10K frame buffer with an auto-wrapping write address.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pio_valid_m10k_writer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 17,
    parameter int DEPTH  = 76800
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              valid_in,
    input  logic [31:0]       data_in,
    input  logic              frame_rst_in,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              ack_out,
    output logic              busy,
    output logic              frame_done,
    output logic [ADDR_W-1:0] addr_out
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    state_t              state_q;
    logic                wr_en_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [DATA_W-1:0]   wr_data_q;
    logic                ack_q;
    logic                busy_q;
    logic                frame_done_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   addr_d;

    generate
        if (DATA_W < 32) begin : g_unused_data
            logic unused_data_bits;
            assign unused_data_bits = ^data_in[31:DATA_W];
        end
    endgenerate

    // Frame clear takes priority over the post-write increment/wrap.
    always_comb begin
        addr_d = addr_q;
        if (state_q == ST_WRITE) begin
            addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
        end
        if (frame_rst_in) begin
            addr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            ack_q        <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            addr_q       <= '0;
        end else begin
            addr_q       <= addr_d;
            wr_en_q      <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (valid_in) begin
                        state_q   <= ST_WRITE;
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= addr_q;
                        wr_data_q <= data_in[DATA_W-1:0];
                        busy_q    <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    state_q      <= ST_ACK;
                    ack_q        <= 1'b1;
                    frame_done_q <= (wr_addr_q == LAST_ADDR);
                end
                ST_ACK: begin
                    if (!valid_in) begin
                        state_q <= ST_IDLE;
                        ack_q   <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ack_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign ack_out    = ack_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign addr_out   = addr_q;

endmodule

`default_nettype wire

// File: tb/tb_pio_valid_m10k_writer.sv
// ============================================================================
// Module   : tb_pio_valid_m10k_writer
// Purpose  : Directed and randomized checks of two writer instances (DEPTH 8
//            and DEPTH 4) against a handshake-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pio_valid_m10k_writer;

    localparam int AW = 17;
    localparam int DW = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        valid_in = 1'b0;
    logic [31:0] data_in = '0;
    logic        frame_rst_in = 1'b0;

    logic          o_wr_en    [2];
    logic [AW-1:0] o_wr_addr  [2];
    logic [DW-1:0] o_wr_data  [2];
    logic          o_ack      [2];
    logic          o_busy     [2];
    logic          o_fd       [2];
    logic [AW-1:0] o_addr     [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pio_valid_m10k_writer #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(8)) u_a (
        .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .data_in(data_in),
        .frame_rst_in(frame_rst_in), .wr_en(o_wr_en[0]), .wr_addr(o_wr_addr[0]),
        .wr_data(o_wr_data[0]), .ack_out(o_ack[0]), .busy(o_busy[0]),
        .frame_done(o_fd[0]), .addr_out(o_addr[0])
    );

    pio_valid_m10k_writer #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(4)) u_b (
        .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .data_in(data_in),
        .frame_rst_in(frame_rst_in), .wr_en(o_wr_en[1]), .wr_addr(o_wr_addr[1]),
        .wr_data(o_wr_data[1]), .ack_out(o_ack[1]), .busy(o_busy[1]),
        .frame_done(o_fd[1]), .addr_out(o_addr[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a request is "open" from acceptance until valid is
    // seen low after the acknowledge; the write itself occupies the first
    // cycle after acceptance.
    int            depth [2] = '{8, 4};
    bit            open_hs [2];
    bit            writing [2];
    logic          e_wr_en   [2];
    logic [AW-1:0] e_wr_addr [2];
    logic [DW-1:0] e_wr_data [2];
    logic          e_ack     [2];
    logic          e_fd      [2];
    int            e_addr    [2];

    always @(posedge clk or negedge reset_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                open_hs[i] = 0; writing[i] = 0;
                e_wr_en[i] = 0; e_wr_addr[i] = '0; e_wr_data[i] = '0;
                e_ack[i] = 0; e_fd[i] = 0; e_addr[i] = 0;
            end else begin
                e_fd[i] = 0;
                if (!open_hs[i]) begin
                    if (valid_in) begin
                        open_hs[i]   = 1;
                        writing[i]   = 1;
                        e_wr_addr[i] = AW'(e_addr[i]);
                        e_wr_data[i] = data_in[DW-1:0];
                    end
                end else if (writing[i]) begin
                    writing[i] = 0;
                    e_ack[i]   = 1;
                    e_fd[i]    = (int'(e_wr_addr[i]) == depth[i] - 1);
                    e_addr[i]  = (e_addr[i] + 1) % depth[i];
                end else if (!valid_in) begin
                    open_hs[i] = 0;
                    e_ack[i]   = 0;
                end
                e_wr_en[i] = writing[i];
                if (frame_rst_in) e_addr[i] = 0;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("m%0d.wr_en", i),      32'(o_wr_en[i]),   32'(e_wr_en[i]));
            chk($sformatf("m%0d.wr_addr", i),    32'(o_wr_addr[i]), 32'(e_wr_addr[i]));
            chk($sformatf("m%0d.wr_data", i),    32'(o_wr_data[i]), 32'(e_wr_data[i]));
            chk($sformatf("m%0d.ack_out", i),    32'(o_ack[i]),     32'(e_ack[i]));
            chk($sformatf("m%0d.busy", i),       32'(o_busy[i]),    32'(open_hs[i]));
            chk($sformatf("m%0d.frame_done", i), 32'(o_fd[i]),      32'(e_fd[i]));
            chk($sformatf("m%0d.addr_out", i),   32'(o_addr[i]),    32'(e_addr[i]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic handshake(input logic [31:0] d);
        data_in  = d;
        valid_in = 1'b1;
        tick();
        tick();
        valid_in = 1'b0;
        tick();
    endtask

    initial begin
        // 1: reset held with a pending request
        reset_n = 1'b0; valid_in = 1'b1; data_in = 32'hFF;
        repeat (3) tick();
        chk("rst.wr_en", 32'(o_wr_en[0]), 32'd0);
        chk("rst.ack", 32'(o_ack[0]), 32'd0);
        chk("rst.wr_data", 32'(o_wr_data[0]), 32'd0);
        valid_in = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();

        // 2: single request latency and capture
        data_in = 32'h0000_01A5; valid_in = 1'b1;
        tick();
        chk("single.wr_en", 32'(o_wr_en[0]), 32'd1);
        chk("single.wr_addr", 32'(o_wr_addr[0]), 32'd0);
        chk("single.wr_data", 32'(o_wr_data[0]), 32'hA5);
        data_in = 32'h0000_0077;
        tick();
        chk("single.ack", 32'(o_ack[0]), 32'd1);
        chk("single.wr_en_low", 32'(o_wr_en[0]), 32'd0);
        chk("single.data_hold", 32'(o_wr_data[0]), 32'hA5);
        valid_in = 1'b0;
        tick();
        chk("single.ack_low", 32'(o_ack[0]), 32'd0);
        chk("single.addr", 32'(o_addr[0]), 32'd1);

        // 4: valid high for only one cycle
        data_in = 32'h11; valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        chk("early.wr_en", 32'(o_wr_en[0]), 32'd1);
        tick();
        chk("early.ack", 32'(o_ack[0]), 32'd1);
        tick();
        chk("early.ack_low", 32'(o_ack[0]), 32'd0);
        chk("early.wr_en_low", 32'(o_wr_en[0]), 32'd0);

        // 5: frame clear during the write of address 5
        repeat (3) handshake(32'h22);
        chk("frst.pre_addr", 32'(o_addr[0]), 32'd5);
        data_in = 32'h3C; valid_in = 1'b1;
        tick();
        frame_rst_in = 1'b1;
        chk("frst.wr_addr", 32'(o_wr_addr[0]), 32'd5);
        tick();
        frame_rst_in = 1'b0;
        chk("frst.addr_out", 32'(o_addr[0]), 32'd0);
        valid_in = 1'b0;
        tick();

        // 3: wrap in the DEPTH=4 instance
        for (int k = 0; k < 4; k++) begin
            data_in = 32'(k + 8'h40); valid_in = 1'b1;
            tick();
            chk("wrap.wr_addr", 32'(o_wr_addr[1]), 32'(k));
            tick();
            chk("wrap.frame_done", 32'(o_fd[1]), (k == 3) ? 32'd1 : 32'd0);
            valid_in = 1'b0;
            tick();
            chk("wrap.fd_pulse", 32'(o_fd[1]), 32'd0);
        end
        valid_in = 1'b1;
        tick();
        chk("wrap.fifth", 32'(o_wr_addr[1]), 32'd0);
        tick();
        valid_in = 1'b0;
        tick();

        // 6: asynchronous reset while acknowledging
        valid_in = 1'b1;
        tick();
        tick();
        chk("rstack.ack_pre", 32'(o_ack[0]), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("rstack.ack", 32'(o_ack[0]), 32'd0);
        chk("rstack.addr", 32'(o_addr[0]), 32'd0);
        valid_in = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        chk("rstack.no_wr", 32'(o_wr_en[0]), 32'd0);
        tick();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 99) < 30) valid_in = ~valid_in;
            data_in      = $urandom;
            frame_rst_in = ($urandom_range(0, 99) < 4);
            if ($urandom_range(0, 399) == 0) begin
                reset_n = 1'b0;
                tick();
                if ($urandom_range(0, 1) == 0) valid_in = 1'b0;
                reset_n = 1'b1;
            end
            tick();
        end
        frame_rst_in = 1'b0;
        valid_in = 1'b0;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
